// File: rtl/approx_pkg.sv
// ---------------------------------------------------------------------------
// approx_pkg
//   Shared definitions for the segmented approximate-adder family
//   (ETAII/ETAIIM) and its error-correction back end.
//   - state_e      : scan FSM states (IDLE / SCAN / DONE)
//   - DEF_SEG_W    : default segment width of the approximate adders
//   - n_seg()      : number of segments for a given width / segment width
// ---------------------------------------------------------------------------
package approx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_SEG_W = 4;

    // Number of SEG_W-bit segments in a WIDTH-bit word.
    function automatic int n_seg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/eta_seg_add.sv
// ---------------------------------------------------------------------------
// eta_seg_add
//   One SEG_W-bit segment of an exact ripple adder.
//   Ports: a, b (SEG_W) operand segments; cin carry-in;
//          sum (SEG_W) segment sum; cout carry-out of the segment.
// ---------------------------------------------------------------------------
module eta_seg_add #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/eta_err_corrector.sv
// ---------------------------------------------------------------------------
// eta_err_corrector
//   Error-correction back end for segmented approximate adders. Latches an
//   operand triple (A, B, Y_apx), recomputes A+B exactly one segment per
//   cycle through a single time-multiplexed eta_seg_add, and reports the
//   exact sum, carry-out and a per-segment mismatch mask against Y_apx.
//
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     in_valid/in_ready        operand handshake
//     in_a, in_b, in_y_apx     operands and approximate sum (WIDTH)
//     out_valid/out_ready      result handshake (valid held until ready)
//     out_y, out_cout          exact sum mod 2^WIDTH and carry-out
//     out_err_mask, out_err    per-segment mismatch mask and its OR
//
//   Optional macro ERR_STATS_EN adds stat_clr, stat_ops, stat_err_ops:
//   saturating counters of completed results and of erroneous results.
// ---------------------------------------------------------------------------
module eta_err_corrector
    import approx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_a,
    input  logic [WIDTH-1:0]              in_b,
    input  logic [WIDTH-1:0]              in_y_apx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_y,
    output logic                          out_cout,
    output logic [n_seg(WIDTH,SEG_W)-1:0] out_err_mask,
    output logic                          out_err
`ifdef ERR_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [31:0]                   stat_ops,
    output logic [31:0]                   stat_err_ops
`endif
);

    localparam int N_SEG = n_seg(WIDTH, SEG_W);
    localparam int IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SEG - 1);

    if ((WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $fatal(1, "eta_err_corrector: WIDTH must be a multiple of SEG_W");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, y_apx_q, y_apx_d;
    logic [IDX_W-1:0]   seg_idx_q, seg_idx_d;
    logic               carry_q, carry_d;
    logic [N_SEG-1:0]   err_mask_q, err_mask_d;
    logic [WIDTH-1:0]   out_y_q, out_y_d;
    logic               out_cout_q, out_cout_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               out_err_q, out_err_d;

    logic [SEG_W-1:0]   seg_a_s, seg_b_s, seg_y_s, seg_sum_s;
    logic               seg_cout_s;

    // The current segment of each latched operand feeds the shared adder.
    assign seg_a_s = a_q[int'(seg_idx_q) * SEG_W +: SEG_W];
    assign seg_b_s = b_q[int'(seg_idx_q) * SEG_W +: SEG_W];
    assign seg_y_s = y_apx_q[int'(seg_idx_q) * SEG_W +: SEG_W];

    eta_seg_add #(.SEG_W(SEG_W)) u_seg_add (
        .a    (seg_a_s),
        .b    (seg_b_s),
        .cin  (carry_q),
        .sum  (seg_sum_s),
        .cout (seg_cout_s)
    );

    // Next-state and next-output logic of the scan FSM.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        y_apx_d     = y_apx_q;
        seg_idx_d   = seg_idx_q;
        carry_d     = carry_q;
        err_mask_d  = err_mask_q;
        out_y_d     = out_y_q;
        out_cout_d  = out_cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    y_apx_d    = in_y_apx;
                    seg_idx_d  = '0;
                    carry_d    = 1'b0;
                    err_mask_d = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SCAN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SCAN: begin
                out_y_d[int'(seg_idx_q) * SEG_W +: SEG_W] = seg_sum_s;
                err_mask_d[seg_idx_q] = (seg_sum_s != seg_y_s);
                carry_d = seg_cout_s;
                if (seg_idx_q == LAST_IDX) begin
                    out_cout_d  = seg_cout_s;
                    out_valid_d = 1'b1;
                    seg_idx_d   = '0;
                    state_d     = ST_DONE;
                end else begin
                    seg_idx_d   = seg_idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // Result is held until the consumer takes it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
        out_err_d = |err_mask_d;
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            y_apx_q     <= '0;
            seg_idx_q   <= '0;
            carry_q     <= 1'b0;
            err_mask_q  <= '0;
            out_y_q     <= '0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_apx_q     <= y_apx_d;
            seg_idx_q   <= seg_idx_d;
            carry_q     <= carry_d;
            err_mask_q  <= err_mask_d;
            out_y_q     <= out_y_d;
            out_cout_q  <= out_cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_y        = out_y_q;
    assign out_cout     = out_cout_q;
    assign out_err_mask = err_mask_q;
    assign out_err      = out_err_q;

`ifdef ERR_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d, stat_err_ops_q, stat_err_ops_d;
    logic        hs_s;

    assign hs_s = out_valid_q && out_ready;

    // Saturating result counters; clear wins over a same-cycle handshake.
    always_comb begin
        stat_ops_d     = stat_ops_q;
        stat_err_ops_d = stat_err_ops_q;
        if (stat_clr) begin
            stat_ops_d     = 32'd0;
            stat_err_ops_d = 32'd0;
        end else begin
            if (hs_s && (stat_ops_q != 32'hFFFF_FFFF)) begin
                stat_ops_d = stat_ops_q + 32'd1;
            end else begin
                stat_ops_d = stat_ops_q;
            end
            if (hs_s && out_err_q && (stat_err_ops_q != 32'hFFFF_FFFF)) begin
                stat_err_ops_d = stat_err_ops_q + 32'd1;
            end else begin
                stat_err_ops_d = stat_err_ops_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q     <= 32'd0;
            stat_err_ops_q <= 32'd0;
        end else begin
            stat_ops_q     <= stat_ops_d;
            stat_err_ops_q <= stat_err_ops_d;
        end
    end

    assign stat_ops     = stat_ops_q;
    assign stat_err_ops = stat_err_ops_q;
`endif

endmodule

// File: tb/tb_eta_err_corrector.sv
// ---------------------------------------------------------------------------
// tb_eta_err_corrector
//   Self-checking bench for eta_err_corrector (WIDTH=32, SEG_W=4). Expected
//   results come from a whole-word reference: exact = A + B as a 33-bit
//   number, and segment i is in error when nibble i of exact differs from
//   nibble i of Y_apx. Define ERR_STATS_EN to also exercise the counters.
// ---------------------------------------------------------------------------
module tb_eta_err_corrector;

    localparam int WIDTH = 32;
    localparam int SEG_W = 4;
    localparam int N_SEG = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  in_a = '0, in_b = '0, in_y_apx = '0;
    logic              in_ready, out_valid, out_cout, out_err;
    logic [WIDTH-1:0]  out_y;
    logic [N_SEG-1:0]  out_err_mask;
`ifdef ERR_STATS_EN
    logic              stat_clr = 1'b0;
    logic [31:0]       stat_ops, stat_err_ops;
`endif

    int checks = 0;
    int failures = 0;

    eta_err_corrector #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_y_apx     (in_y_apx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_cout     (out_cout),
        .out_err_mask (out_err_mask),
        .out_err      (out_err)
`ifdef ERR_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_ops     (stat_ops),
        .stat_err_ops (stat_err_ops)
`endif
    );

    always #5 clk = ~clk;

    // Reference: whole-word add, nibble-wise comparison against Y_apx.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] y, output logic [31:0] ey,
                                  output logic ec, output logic [7:0] em);
        logic [32:0] s;
        s  = 33'(a) + 33'(b);
        ey = s[31:0];
        ec = s[32];
        for (int i = 0; i < N_SEG; i++)
            em[i] = ((ey >> (4 * i)) & 32'hF) != ((y >> (4 * i)) & 32'hF);
    endfunction

    // Offer one triple while idle, then wait (bounded) for out_valid.
    // cycles = number of edges after the accept edge until out_valid seen.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] y, output int cycles);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_y_apx = y;
        @(negedge clk);
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_y_apx = $urandom;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_y, out_cout, out_err_mask, out_err} !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b y=%h c=%b m=%h e=%b, want rdy=1 vld=0 rest 0",
                     in_ready, out_valid, out_y, out_cout, out_err_mask, out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
        logic [31:0] tb [2] = '{32'h0000_0001, 32'h0000_0001};
        logic [31:0] ty [2] = '{32'h0000_0000, 32'h0000_0000};
        logic [31:0] ey; logic ec; logic [7:0] em; int cyc;
        for (int i = 0; i < 2; i++) begin
            model(ta[i], tb[i], ty[i], ey, ec, em);
            send_op(ta[i], tb[i], ty[i], cyc);
            checks++;
            if ({out_y, out_cout, out_err_mask, out_err} !== {ey, ec, em, |em}) begin
                failures++;
                $display("FAIL directed_%0d: got y=%h c=%b m=%h e=%b, want y=%h c=%b m=%h e=%b",
                         i, out_y, out_cout, out_err_mask, out_err, ey, ec, em, |em);
            end
            release_op();
        end
    endtask

    task automatic test_latency();
        int k;
        @(negedge clk);
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_y_apx = $urandom;
        @(negedge clk);   // just after accept edge E0
        in_valid = 1'b0;
        for (k = 0; k <= N_SEG; k++) begin
            checks++;
            if (out_valid !== (k == N_SEG) || (k >= 1 && in_ready !== 1'b0)) begin
                failures++;
                $display("FAIL latency_edge_%0d: got vld=%b rdy=%b, want vld=%b rdy=0",
                         k, out_valid, in_ready, (k == N_SEG));
            end
            if (k < N_SEG) @(negedge clk);
        end
        release_op();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL latency_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, y, ey; logic ec; logic [7:0] em; int cyc, mode, hold;
        for (int n = 0; n < 24; n++) begin
            a = (n == 0) ? 32'hFFFF_FFFF : $urandom;
            b = (n == 0) ? 32'hFFFF_FFFF : $urandom;
            mode = $urandom_range(0, 2);
            model(a, b, 32'h0, ey, ec, em);
            if (mode == 0) y = ey;
            else if (mode == 1) y = ey ^ $urandom;
            else y = ey ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, 7)));
            model(a, b, y, ey, ec, em);
            send_op(a, b, y, cyc);
            checks++;
            if (cyc !== N_SEG) begin
                failures++;
                $display("FAIL rand_latency_%0d: got %0d edges, want %0d", n, cyc, N_SEG);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            checks++;
            if ({out_valid, out_y, out_cout, out_err_mask, out_err} !== {1'b1, ey, ec, em, |em}) begin
                failures++;
                $display("FAIL rand_result_%0d: got v=%b y=%h c=%b m=%h e=%b, want v=1 y=%h c=%b m=%h e=%b",
                         n, out_valid, out_y, out_cout, out_err_mask, out_err, ey, ec, em, |em);
            end
            release_op();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, y, ey; logic ec; logic [7:0] em; int cyc;
        a = 32'h89AB_CDEF; b = 32'h7654_3211; y = 32'h0000_F000;
        model(a, b, y, ey, ec, em);
        send_op(a, b, y, cyc);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0]; in_a = $urandom; in_b = $urandom; in_y_apx = $urandom;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, out_y, out_cout, out_err_mask} !== {1'b1, 1'b0, ey, ec, em}) begin
                failures++;
                $display("FAIL backpressure_%0d: got v=%b r=%b y=%h c=%b m=%h, want v=1 r=0 y=%h c=%b m=%h",
                         k, out_valid, in_ready, out_y, out_cout, out_err_mask, ey, ec, em);
            end
        end
        in_valid = 1'b0;
        release_op();
        repeat (10) @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL backpressure_no_ghost: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] ey; logic ec; logic [7:0] em; int cyc;
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_y_apx = 32'h0;
        @(negedge clk);   // after E0
        in_valid = 1'b0;
        repeat (3) @(negedge clk);  // after E1..E3
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_y, out_cout, out_err_mask, out_err} !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_scan: got rdy=%b vld=%b y=%h c=%b m=%h e=%b, want rdy=1 vld=0 rest 0",
                     in_ready, out_valid, out_y, out_cout, out_err_mask, out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model(32'hDEAD_BEEF, 32'h2152_4111, 32'h0000_0000, ey, ec, em);
        send_op(32'hDEAD_BEEF, 32'h2152_4111, 32'h0000_0000, cyc);
        checks++;
        if ({out_y, out_cout, out_err_mask, out_err} !== {ey, ec, em, |em}) begin
            failures++;
            $display("FAIL reset_then_op: got y=%h c=%b m=%h e=%b, want y=%h c=%b m=%h e=%b",
                     out_y, out_cout, out_err_mask, out_err, ey, ec, em, |em);
        end
        release_op();
    endtask

`ifdef ERR_STATS_EN
    task automatic test_stats();
        logic [31:0] a, b, ey; logic ec; logic [7:0] em; int cyc;
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int n = 0; n < 5; n++) begin
            a = $urandom; b = $urandom;
            model(a, b, 32'h0, ey, ec, em);
            send_op(a, b, (n == 1 || n == 3) ? (ey ^ 32'h0000_0010) : ey, cyc);
            release_op();
        end
        checks++;
        if ({stat_ops, stat_err_ops} !== {32'd5, 32'd2}) begin
            failures++;
            $display("FAIL stats_count: got ops=%0d err=%0d, want ops=5 err=2", stat_ops, stat_err_ops);
        end
        send_op(32'h1, 32'h1, 32'h0, cyc);
        stat_clr = 1'b1;
        release_op();
        stat_clr = 1'b0;
        checks++;
        if ({stat_ops, stat_err_ops} !== {32'd0, 32'd0}) begin
            failures++;
            $display("FAIL stats_clear: got ops=%0d err=%0d, want 0 0", stat_ops, stat_err_ops);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_random();
        test_backpressure();
        test_reset_mid_scan();
`ifdef ERR_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
